comparison_serial_rx: RTL
=========================

Name: comparison_serial_rx

Overview:
Bit-serial receiving end for the comparison unit's operands. Operands x and y arrive one bit per cycle, MSB first, over a valid-qualified serial link. The block decides equal/less/greater on the fly, reassembles both operands, and delivers a 9-bit result in the same select encoding as the parallel comparison path. It sits between the serial operand link and the ALU result mux.

Parameters:
WIDTH, 4, operand width in bits; legal range 1..8 so that the max result fits in result[7:0]

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to begin a new compare; sampled only in IDLE
select  input  2  operation, latched on accepted start: 0 equal, 1 less-than, 2 greater-than, 3 max
bit_valid  input  1  x_bit/y_bit carry a valid operand bit this cycle
x_bit  input  1  current bit of operand x, MSB first
y_bit  input  1  current bit of operand y, MSB first
busy  output  1  high in RECV and DONE
done  output  1  one-cycle pulse; result is updated in the same cycle
result  output  9  zero-extended result: bit0 = flag for select 0/1/2, [WIDTH-1:0] = max for select 3

Behaviour:
- Reset (async, at any time, including mid-receive): state IDLE; busy=0, done=0, result=0; bit count, x/y shift registers, gt/lt flags and the latched select are all cleared.
- FSM states: IDLE, RECV, DONE.
- IDLE: start=1 latches select, clears gt/lt/count/shift registers, and moves to RECV. bit_valid is ignored in IDLE, including in the start cycle. The first bit is accepted in the cycle after start.
- RECV: on each cycle with bit_valid=1:
  - shift x_bit into xs and y_bit into ys (LSB end), and increment count;
  - if gt=0 and lt=0: x_bit=1 with y_bit=0 sets gt; x_bit=0 with y_bit=1 sets lt;
  - once gt or lt is set, it never changes for the rest of the operand (MSB decides).
- bit_valid=0 in RECV: hold all state. Gaps of any length are allowed; there is no timeout.
- start in RECV or DONE: ignored. select changes after an accepted start are ignored.
- When the WIDTH-th bit is accepted, next state is DONE. The result is computed from the final flags and registers, using the full operands including the last bit.
- DONE (exactly one cycle):
  - done=1 and result is registered in this cycle;
  - bit_valid is ignored;
  - next state is IDLE.
- Result encoding:
  - select 0: {8'b0, ~gt & ~lt}
  - select 1: {8'b0, lt}
  - select 2: {8'b0, gt}
  - select 3: zero-extended (lt ? ys : xs); when the operands are equal this returns x.
- result holds its value between done pulses and changes only in the DONE cycle or on reset.
- Latency: done fires 1 cycle after the cycle that accepts the WIDTH-th bit. With no gaps, done fires WIDTH+1 cycles after the start cycle.
- Back-to-back operation: start is accepted again in the first IDLE cycle after DONE.
- All operands are unsigned.

Test Plan:
- Equal: start with select=0, x=y=4'b1010 sent with no gaps -> done pulses exactly 5 cycles after start, result=9'h001, busy low the cycle after done.
- Less-than with gaps: select=1, x=0011, y=0101, one idle cycle (bit_valid=0) between each bit -> result=9'h001. Repeat with select=2 -> result=9'h000.
- MSB dominance: select=2, x=1000, y=0111 -> result=9'h001. With select=1 -> result=9'h000. Flags are unaffected by the lower bits.
- Max: select=3, x=0110, y=1001 -> result=9'h009. With x=y=1111 -> result=9'h00F. With x=1100, y=0011 -> result=9'h00C.
- Protocol boundaries: start plus bit_valid in the same IDLE cycle -> that bit is dropped. start asserted during RECV -> ignored, select is not relatched. result holds 9'h009 until the next done.
- Reset mid-receive: assert reset after 2 of 4 bits -> busy=0, result=0 immediately (asynchronously). A fresh start followed by x=0001, y=0000 with select=2 -> result=9'h001.

Source files
------------

// File: rtl/comparison_serial_rx.sv
// Bit-serial operand receiver for the comparison unit.
// Takes x and y one bit per cycle, MSB first, and settles equal/less/greater
// as the bits arrive. It rebuilds both operands so that a max can be returned.
// The result uses the same 9-bit select encoding as the parallel compare path.
module comparison_serial_rx #(
    parameter int WIDTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] select,
    input  logic       bit_valid,
    input  logic       x_bit,
    input  logic       y_bit,
    output logic       busy,
    output logic       done,
    output logic [8:0] result
);

    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] xs_q, xs_d;
    logic [WIDTH-1:0] ys_q, ys_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic [8:0]       result_q, result_d;

    // Map the final flags and operands onto the shared select encoding.
    // For max, equal operands return x. The same value is returned either way.
    function automatic logic [8:0] encode_result(
        input logic [1:0]       sel,
        input logic             gt,
        input logic             lt,
        input logic [WIDTH-1:0] xs,
        input logic [WIDTH-1:0] ys
    );
        case (sel)
            2'd0:    return {8'b0, ~gt & ~lt};
            2'd1:    return {8'b0, lt};
            2'd2:    return {8'b0, gt};
            default: return 9'(lt ? ys : xs);
        endcase
    endfunction

    // Next-state logic: accept a start in IDLE, shift and decide in RECV, hold DONE for one cycle.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        xs_d     = xs_q;
        ys_d     = ys_q;
        gt_d     = gt_q;
        lt_d     = lt_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                // bit_valid is deliberately ignored here, even in the start cycle
                if (start) begin
                    sel_d   = select;
                    cnt_d   = '0;
                    xs_d    = '0;
                    ys_d    = '0;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    state_d = S_RECV;
                end
            end
            S_RECV: begin
                if (bit_valid) begin
                    xs_d  = (xs_q << 1) | WIDTH'(x_bit);
                    ys_d  = (ys_q << 1) | WIDTH'(y_bit);
                    cnt_d = cnt_q + CW'(1);
                    // The first differing bit (MSB side) decides. Later bits cannot change it.
                    if (!gt_q && !lt_q) begin
                        gt_d = x_bit & ~y_bit;
                        lt_d = ~x_bit & y_bit;
                    end
                    // Build the result from the post-update values so the last bit counts.
                    if (cnt_q == LAST_BIT) begin
                        state_d  = S_DONE;
                        result_d = encode_result(sel_q, gt_d, lt_d, xs_d, ys_d);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset clears everything asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            sel_q    <= '0;
            cnt_q    <= '0;
            xs_q     <= '0;
            ys_q     <= '0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            xs_q     <= xs_d;
            ys_q     <= ys_d;
            gt_q     <= gt_d;
            lt_q     <= lt_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule
